pixel_stream_gen: RTL and testbench

//  Raster pixel source driving the line-buffer/Sobel processing chain: emits a 12-bit pixel per

---
 rtl/pixgen_pkg.sv | 16 +
 rtl/pixgen_lfsr.sv | 21 ++
 rtl/pixel_stream_gen.sv | 133 +++++++++++++
 tb/tb_pixel_stream_gen.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixgen_pkg.sv
// pixgen_pkg: shared FSM/pattern types, LFSR constants and step function for pixel_stream_gen
package pixgen_pkg;

    typedef enum logic [1:0] {IDLE, ACTIVE, HBLANK, VBLANK} state_t;
    typedef enum logic [1:0] {RAMP_H, RAMP_V, CHECKER, LFSR} mode_t;

    localparam logic [11:0] LFSR_SEED = 12'hACE;
    // x^12+x^11+x^10+x^4+1 -> feedback from bits 11, 10, 9 and 3
    localparam logic [11:0] LFSR_TAPS = 12'hE08;
    localparam int          CHK_SHIFT = 3;

    function automatic logic [11:0] lfsr_step(input logic [11:0] q);
        return {q[10:0], ^(q & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/pixgen_lfsr.sv
// pixgen_lfsr: 12-bit Fibonacci LFSR holding the value of the next pixel to be emitted
module pixgen_lfsr
    import pixgen_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        reseed,
    output logic [11:0] q
);

    // The seed itself goes out as the first pixel of a frame, so a reseed loads its successor
    always_ff @(posedge clk or posedge rst)
        if (rst)
            q <= LFSR_SEED;
        else if (reseed)
            q <= lfsr_step(LFSR_SEED);
        else if (en)
            q <= lfsr_step(q);

endmodule

// File: rtl/pixel_stream_gen.sv
// pixel_stream_gen: raster test-pattern source with DVAL and X/Y counters; PIXGEN_LFSR_EN enables the LFSR pattern
module pixel_stream_gen
    import pixgen_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_BLANK  = 160,
    parameter int V_ACTIVE = 480,
    parameter int V_BLANK  = 45,
    parameter int DW       = 12
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic          iSTART,
    input  logic          iSTOP,
    input  logic [1:0]    iMODE,
    output logic [DW-1:0] oDATA,
    output logic          oDVAL,
    output logic [15:0]   oX_Cont,
    output logic [15:0]   oY_Cont,
    output logic [31:0]   oFrame_Cont,
    output logic          oBUSY
);

    localparam int LINE = H_ACTIVE + H_BLANK;
    localparam int CW   = $clog2(V_BLANK * LINE + 1);

    state_t        state, state_n;
    mode_t         mode, mode_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [15:0]   x_n, y_n;
    logic [31:0]   frame_n;
    logic          stop_pend, stop_n, start_frame;
    logic [DW-1:0] pix_n, lfsr_pix;

`ifdef PIXGEN_LFSR_EN
    logic [11:0] lfsr_q;

    pixgen_lfsr u_lfsr (
        .clk    (iCLK),
        .rst    (iRST),
        .en     (state_n == ACTIVE),
        .reseed (start_frame),
        .q      (lfsr_q)
    );

    assign lfsr_pix = start_frame ? DW'(LFSR_SEED) : DW'(lfsr_q);
`else
    assign lfsr_pix = {1'b1, {DW-1{1'b0}}};
`endif

    // Next state, counters and the pixel value that goes out with them on the next edge
    always_comb begin
        state_n     = state;
        mode_n      = mode;
        cnt_n       = cnt;
        x_n         = oX_Cont;
        y_n         = oY_Cont;
        frame_n     = oFrame_Cont;
        stop_n      = stop_pend | (iSTOP && state != IDLE);
        start_frame = 1'b0;
        case (state)
            IDLE:
                if (iSTART) begin
                    state_n     = ACTIVE;
                    x_n         = '0;
                    y_n         = '0;
                    stop_n      = iSTOP;
                    start_frame = 1'b1;
                end
            ACTIVE:
                if (oX_Cont == 16'(H_ACTIVE - 1)) begin
                    state_n = HBLANK;
                    x_n     = '0;
                    cnt_n   = '0;
                end else
                    x_n = oX_Cont + 16'd1;
            HBLANK:
                if (cnt == CW'(H_BLANK - 1)) begin
                    cnt_n   = '0;
                    state_n = (oY_Cont == 16'(V_ACTIVE - 1)) ? VBLANK : ACTIVE;
                    y_n     = (oY_Cont == 16'(V_ACTIVE - 1)) ? 16'd0 : oY_Cont + 16'd1;
                end else
                    cnt_n = cnt + 1'b1;
            VBLANK:
                if (cnt == CW'(V_BLANK * LINE - 1)) begin
                    cnt_n   = '0;
                    frame_n = oFrame_Cont + 32'd1;
                    if (stop_pend || iSTOP) begin
                        state_n = IDLE;
                        stop_n  = 1'b0;
                    end else begin
                        state_n     = ACTIVE;
                        start_frame = 1'b1;
                    end
                end else
                    cnt_n = cnt + 1'b1;
            default: state_n = IDLE;
        endcase
        if (start_frame)
            mode_n = mode_t'(iMODE);
        pix_n = (state_n != ACTIVE) ? '0 :
                (mode_n == RAMP_H)  ? DW'(x_n) :
                (mode_n == RAMP_V)  ? DW'(y_n) :
                (mode_n == CHECKER) ? {DW{x_n[CHK_SHIFT] ^ y_n[CHK_SHIFT]}} : lfsr_pix;
    end

    // State register and registered outputs, all cleared by the asynchronous reset
    always_ff @(posedge iCLK or posedge iRST)
        if (iRST) begin
            state       <= IDLE;
            mode        <= RAMP_H;
            cnt         <= '0;
            stop_pend   <= 1'b0;
            oDATA       <= '0;
            oDVAL       <= 1'b0;
            oX_Cont     <= '0;
            oY_Cont     <= '0;
            oFrame_Cont <= '0;
            oBUSY       <= 1'b0;
        end else begin
            state       <= state_n;
            mode        <= mode_n;
            cnt         <= cnt_n;
            stop_pend   <= stop_n;
            oDATA       <= pix_n;
            oDVAL       <= state_n == ACTIVE;
            oX_Cont     <= x_n;
            oY_Cont     <= y_n;
            oFrame_Cont <= frame_n;
            oBUSY       <= state_n != IDLE;
        end

endmodule

// File: tb/tb_pixel_stream_gen.sv
// tb_pixel_stream_gen: scoreboard bench for pixel_stream_gen (4x3 frame with 2/1 blanking, plus a 16x16 instance)
module tb_pixel_stream_gen;

    typedef struct packed {
        logic [11:0] d;
        logic [15:0] x;
        logic [15:0] y;
    } pix_t;

    logic        clk = 1'b0, rst = 1'b1, sel = 1'b0;
    logic        a_start = 1'b0, a_stop = 1'b0, b_start = 1'b0, b_stop = 1'b0;
    logic [1:0]  a_mode = 2'd0, b_mode = 2'd0;
    logic [11:0] a_data, b_data, od;
    logic        a_dval, b_dval, a_busy, b_busy, odv, obusy;
    logic [15:0] a_x, a_y, b_x, b_y, ox, oy;
    logic [31:0] a_frame, b_frame, ofr;
    logic [11:0] img [256];
    pix_t        q[$];
    int          errors = 0, checks = 0;

    pixel_stream_gen #(.H_ACTIVE(4), .H_BLANK(2), .V_ACTIVE(3), .V_BLANK(1), .DW(12)) dut_a (
        .iCLK(clk), .iRST(rst), .iSTART(a_start), .iSTOP(a_stop), .iMODE(a_mode),
        .oDATA(a_data), .oDVAL(a_dval), .oX_Cont(a_x), .oY_Cont(a_y),
        .oFrame_Cont(a_frame), .oBUSY(a_busy)
    );

    pixel_stream_gen #(.H_ACTIVE(16), .H_BLANK(2), .V_ACTIVE(16), .V_BLANK(1), .DW(12)) dut_b (
        .iCLK(clk), .iRST(rst), .iSTART(b_start), .iSTOP(b_stop), .iMODE(b_mode),
        .oDATA(b_data), .oDVAL(b_dval), .oX_Cont(b_x), .oY_Cont(b_y),
        .oFrame_Cont(b_frame), .oBUSY(b_busy)
    );

    assign od    = sel ? b_data  : a_data;
    assign odv   = sel ? b_dval  : a_dval;
    assign ox    = sel ? b_x     : a_x;
    assign oy    = sel ? b_y     : a_y;
    assign ofr   = sel ? b_frame : a_frame;
    assign obusy = sel ? b_busy  : a_busy;

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst = 1'b1;
        a_start = 1'b0; a_stop = 1'b0; b_start = 1'b0; b_stop = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        @(negedge clk);
    endtask

    task automatic push_frame(input int m, input int ha, input int va);
        logic [11:0] l, d;
        logic [15:0] x16, y16;
        l = 12'hACE;
        for (int y = 0; y < va; y++)
            for (int x = 0; x < ha; x++) begin
                x16 = 16'(x);
                y16 = 16'(y);
                case (m)
                    0: d = x16[11:0];
                    1: d = y16[11:0];
                    2: d = (x16[3] ^ y16[3]) ? 12'hFFF : 12'h000;
                    default: begin
`ifdef PIXGEN_LFSR_EN
                        d = l;
                        l = {l[10:0], l[11] ^ l[10] ^ l[9] ^ l[3]};
`else
                        d = 12'h800;
`endif
                    end
                endcase
                q.push_back('{d: d, x: x16, y: y16});
            end
    endtask

    task automatic consume(input int budget, input int stop_y);
        int   n = 0;
        bit   sent = 0;
        pix_t e;
        while (q.size() > 0 && n < budget) begin
            if (odv) begin
                e = q.pop_front();
                checks++;
                if (od !== e.d || ox !== e.x || oy !== e.y) begin
                    errors++;
                    $display("FAIL pixel: got d=%h x=%0d y=%0d want d=%h x=%0d y=%0d", od, ox, oy, e.d, e.x, e.y);
                end
                if (ox < 16 && oy < 16)
                    img[{oy[3:0], ox[3:0]}] = od;
                if (stop_y >= 0 && !sent && oy == 16'(stop_y)) begin
                    a_stop = 1'b1;
                    sent = 1;
                end
            end
            @(negedge clk);
            a_stop = 1'b0;
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL pixel_timeout: got %0d pixels left want 0", q.size());
        end
    endtask

    task automatic finish_idle(input int budget);
        int n = 0, extra = 0;
        while (obusy && n < budget) begin
            if (odv) extra++;
            @(negedge clk);
            n++;
        end
        checks++;
        if (obusy !== 1'b0) begin
            errors++;
            $display("FAIL busy_timeout: got busy=%b want 0", obusy);
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL extra_pixels: got %0d want 0", extra);
        end
        checks++;
        if (ofr !== 32'd1) begin
            errors++;
            $display("FAIL frame_count: got %0d want 1", ofr);
        end
    endtask

    task automatic stays_idle(input int cycles);
        int bad = 0;
        for (int i = 0; i < cycles; i++) begin
            if (odv || obusy) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stays_idle: got %0d active cycles want 0", bad);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_start = 1'b1;
        @(negedge clk);
        checks++;
        if (a_data !== 12'd0 || a_dval !== 1'b0 || a_x !== 16'd0 || a_y !== 16'd0) begin
            errors++;
            $display("FAIL reset_pixel: got d=%h v=%b x=%0d y=%0d want all 0", a_data, a_dval, a_x, a_y);
        end
        checks++;
        if (a_frame !== 32'd0 || a_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: got frame=%0d busy=%b want 0 0", a_frame, a_busy);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (a_dval !== 1'b1 || a_busy !== 1'b1 || a_x !== 16'd0 || a_y !== 16'd0) begin
            errors++;
            $display("FAIL reset_release: got v=%b busy=%b x=%0d y=%0d want 1 1 0 0", a_dval, a_busy, a_x, a_y);
        end
        a_start = 1'b0;
        do_reset();
    endtask

    task automatic test_ramp();
        pix_t        e;
        logic        e_dv;
        logic [15:0] e_y;
        sel = 1'b0;
        a_mode = 2'd0;
        push_frame(0, 4, 3);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        for (int c = 0; c < 24; c++) begin
            e_dv = (c < 18) && (c % 6 < 4);
            e_y  = (c < 18) ? 16'(c / 6) : 16'd0;
            checks++;
            if (a_dval !== e_dv) begin
                errors++;
                $display("FAIL ramp_dval c=%0d: got %b want %b", c, a_dval, e_dv);
            end
            if (a_dval && q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (a_data !== e.d || a_x !== e.x || a_y !== e.y) begin
                    errors++;
                    $display("FAIL ramp_pixel: got d=%h x=%0d y=%0d want d=%h x=%0d y=%0d", a_data, a_x, a_y, e.d, e.x, e.y);
                end
            end else if (!a_dval) begin
                checks++;
                if (a_x !== 16'd0 || a_y !== e_y || a_frame !== 32'd0 || a_busy !== 1'b1) begin
                    errors++;
                    $display("FAIL ramp_blank c=%0d: got x=%0d y=%0d frame=%0d busy=%b want 0 %0d 0 1", c, a_x, a_y, a_frame, a_busy, e_y);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (a_frame !== 32'd1 || a_dval !== 1'b1 || a_x !== 16'd0 || a_y !== 16'd0) begin
            errors++;
            $display("FAIL ramp_next_frame: got frame=%0d v=%b x=%0d y=%0d want 1 1 0 0", a_frame, a_dval, a_x, a_y);
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL ramp_count: got %0d pixels missing want 0", q.size());
        end
        do_reset();
    endtask

    task automatic test_checker();
        sel = 1'b1;
        b_mode = 2'd2;
        push_frame(2, 16, 16);
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        consume(600, -1);
        checks++;
        if (img[8] !== 12'hFFF) begin
            errors++;
            $display("FAIL checker_8_0: got %h want fff", img[8]);
        end
        checks++;
        if (img[8*16+8] !== 12'h000) begin
            errors++;
            $display("FAIL checker_8_8: got %h want 000", img[8*16+8]);
        end
        checks++;
        if (img[8*16] !== 12'hFFF) begin
            errors++;
            $display("FAIL checker_0_8: got %h want fff", img[8*16]);
        end
        sel = 1'b0;
        do_reset();
    endtask

    task automatic test_stop();
        sel = 1'b0;
        a_mode = 2'd1;
        push_frame(1, 4, 3);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        consume(100, 1);
        finish_idle(50);
        stays_idle(10);
        do_reset();
    endtask

    task automatic test_start_stop();
        sel = 1'b0;
        a_mode = 2'd0;
        push_frame(0, 4, 3);
        a_start = 1'b1;
        a_stop = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        a_stop = 1'b0;
        consume(100, -1);
        finish_idle(50);
        stays_idle(10);
        do_reset();
    endtask

    task automatic test_async_reset();
        int          n = 0;
        logic [11:0] first;
`ifdef PIXGEN_LFSR_EN
        first = 12'hACE;
`else
        first = 12'h800;
`endif
        sel = 1'b0;
        a_mode = 2'd0;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        while (!(a_y == 16'd1 && a_x == 16'd2) && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (a_y !== 16'd1 || a_x !== 16'd2) begin
            errors++;
            $display("FAIL async_reach: got x=%0d y=%0d want 2 1", a_x, a_y);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (a_data !== 12'd0 || a_dval !== 1'b0 || a_x !== 16'd0 || a_y !== 16'd0 || a_busy !== 1'b0 || a_frame !== 32'd0) begin
            errors++;
            $display("FAIL async_reset: got d=%h v=%b x=%0d y=%0d busy=%b frame=%0d want all 0", a_data, a_dval, a_x, a_y, a_busy, a_frame);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        a_mode = 2'd3;
        push_frame(3, 4, 3);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        checks++;
        if (a_data !== first || a_x !== 16'd0 || a_y !== 16'd0 || a_dval !== 1'b1) begin
            errors++;
            $display("FAIL mode3_first: got d=%h x=%0d y=%0d v=%b want d=%h x=0 y=0 v=1", a_data, a_x, a_y, a_dval, first);
        end
        consume(100, -1);
        checks++;
        if (a_frame !== 32'd0) begin
            errors++;
            $display("FAIL partial_frame: got frame=%0d want 0", a_frame);
        end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_checker();
        test_stop();
        test_start_stop();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
